// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / memory-wait stall sequencer with a stall counter and a sticky timeout flag.
// Optional ZERO_REG_NOHAZARD_EN: treat r0 as hardwired zero, so loads into r0 never stall.
module hazard_stall_ctrl #(
    parameter int REG_W        = 4,
    parameter int MEM_WAIT_MAX = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_readReg0,
    input  logic [REG_W-1:0] id_readReg1,
    input  logic             id_immediate,
    input  logic             id_valid,
    input  logic             ex_write,
    input  logic             ex_ReadMem,
    input  logic [REG_W-1:0] ex_writeReg,
    input  logic             mem_busy,
    output logic             stall,
    output logic             bubble,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LU  = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;
    localparam logic [1:0] S_ERR = 2'd3;

    logic [1:0]       r_state;
    logic [7:0]       r_wait;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_next;
    logic             w_match;
    logic             w_load_use;
    logic             w_wait_max;

    assign w_match = (ex_writeReg == id_readReg0) | (!id_immediate & (ex_writeReg == id_readReg1));
`ifdef ZERO_REG_NOHAZARD_EN
    assign w_load_use = id_valid & ex_write & ex_ReadMem & w_match & (ex_writeReg != '0);
`else
    assign w_load_use = id_valid & ex_write & ex_ReadMem & w_match;
`endif
    assign w_wait_max = r_wait == 8'(MEM_WAIT_MAX);

    always_comb begin
        w_next = r_state == S_RUN ? (mem_busy ? S_MW : w_load_use ? S_LU : S_RUN) :
                 r_state == S_MW  ? (!mem_busy ? S_RUN : w_wait_max ? S_ERR : S_MW) :
                 r_state == S_ERR ? S_ERR : S_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_wait    <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_wait    <= w_next == S_RUN ? 8'd0 :
                         (r_state == S_RUN && w_next == S_MW) ? 8'd1 :
                         (r_state == S_MW && w_next == S_MW) ? r_wait + 8'd1 : r_wait;
            r_timeout <= r_timeout | (r_state == S_MW && w_next == S_ERR);
            // saturate instead of wrapping so long hangs stay visible
            r_cnt     <= (r_state != S_RUN && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
        end
    end

    assign stall        = r_state != S_RUN;
    assign bubble       = r_state == S_LU;
    assign timeout_err  = r_timeout;
    assign stall_cycles = r_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random stimulus checked against a cycle-level reference model.
module tb_hazard_stall_ctrl;
    localparam int REG_W = 4;
    localparam int MAXW  = 8;
    localparam int CW    = 8;
    localparam int SAT   = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [REG_W-1:0] id_readReg0 = '0, id_readReg1 = '0, ex_writeReg = '0;
    logic             id_immediate = 1'b0, id_valid = 1'b0, ex_write = 1'b0, ex_ReadMem = 1'b0, mem_busy = 1'b0;
    logic             stall, bubble, timeout_err;
    logic [CW-1:0]    stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: stall reasons tracked as counts and flags
    int m_wait = 0;
    bit m_lu   = 0;
    bit m_err  = 0;
    bit m_to   = 0;
    int m_cnt  = 0;

    hazard_stall_ctrl #(.REG_W(REG_W), .MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_readReg0(id_readReg0), .id_readReg1(id_readReg1), .id_immediate(id_immediate),
        .id_valid(id_valid), .ex_write(ex_write), .ex_ReadMem(ex_ReadMem), .ex_writeReg(ex_writeReg),
        .mem_busy(mem_busy), .stall(stall), .bubble(bubble), .timeout_err(timeout_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hazard();
        bit h;
        h = id_valid && ex_write && ex_ReadMem &&
            (ex_writeReg == id_readReg0 || (!id_immediate && ex_writeReg == id_readReg1));
`ifdef ZERO_REG_NOHAZARD_EN
        h = h && ex_writeReg != 0;
`endif
        return h;
    endfunction

    task automatic model_step();
        bit stalled;
        stalled = m_err || m_wait > 0 || m_lu;
        if (rst) begin
            m_wait = 0; m_lu = 0; m_err = 0; m_to = 0; m_cnt = 0;
        end else begin
            if (stalled && m_cnt < SAT) m_cnt++;
            if (m_err) begin
            end else if (m_wait > 0) begin
                if (!mem_busy) m_wait = 0;
                else if (m_wait == MAXW) begin m_wait = 0; m_err = 1; m_to = 1; end
                else m_wait++;
            end else if (m_lu) m_lu = 0;
            else if (mem_busy) m_wait = 1;
            else if (hazard()) m_lu = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("stall", int'(stall), int'(m_err || m_wait > 0 || m_lu));
        check("bubble", int'(bubble), int'(m_lu));
        check("timeout_err", int'(timeout_err), int'(m_to));
        check("stall_cycles", int'(stall_cycles), m_cnt);
    endtask

    task automatic set_ex(input bit ld, input int wr, input int r0, input int r1, input bit imm);
        id_valid = 1; ex_write = ld; ex_ReadMem = ld;
        ex_writeReg = REG_W'(wr); id_readReg0 = REG_W'(r0); id_readReg1 = REG_W'(r1); id_immediate = imm;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        int busy_left;
        // reset held two cycles with mem_busy asserted
        rst = 1; mem_busy = 1;
        tick(); tick();
        rst = 0; mem_busy = 0;
        check("rst_stall", int'(stall), 0);
        check("rst_bubble", int'(bubble), 0);
        check("rst_timeout", int'(timeout_err), 0);
        check("rst_cnt", int'(stall_cycles), 0);

        // load-use on readReg0
        set_ex(1, 3, 3, 7, 0);
        tick();
        check("lu_stall", int'(stall), 1);
        check("lu_bubble", int'(bubble), 1);
        set_ex(0, 3, 3, 7, 0);
        tick();
        check("lu_end", int'(stall), 0);
        check("lu_cnt", int'(stall_cycles), 1);

        // immediate masks readReg1
        set_ex(1, 5, 2, 5, 1);
        tick();
        check("imm_mask", int'(stall), 0);
        set_ex(1, 5, 2, 5, 0);
        tick();
        check("imm_off_bubble", int'(bubble), 1);
        set_ex(0, 5, 2, 5, 0);
        tick();
        check("imm_off_end", int'(stall), 0);

        // memory wait wins over a simultaneous hazard
        do_reset();
        set_ex(1, 4, 4, 0, 0);
        mem_busy = 1;
        repeat (3) begin
            tick();
            check("mw_stall", int'(stall), 1);
            check("mw_bubble", int'(bubble), 0);
        end
        mem_busy = 0;
        tick();
        check("mw_run", int'(stall), 0);
        tick();
        check("mw_lu", int'(bubble), 1);
        set_ex(0, 4, 4, 0, 0);
        tick();
        check("mw_cnt", int'(stall_cycles), 4);

        // exactly MEM_WAIT_MAX busy cycles does not time out
        do_reset();
        mem_busy = 1;
        repeat (MAXW) tick();
        mem_busy = 0;
        tick();
        check("max_no_to", int'(timeout_err), 0);
        check("max_run", int'(stall), 0);

        // one more busy cycle does
        mem_busy = 1;
        repeat (MAXW + 1) tick();
        mem_busy = 0;
        tick(); tick();
        check("to_flag", int'(timeout_err), 1);
        check("to_stall", int'(stall), 1);
        // stay in ERR long enough to saturate the counter
        repeat (SAT + 20) tick();
        check("sat_cnt", int'(stall_cycles), SAT);
        do_reset();
        check("to_clear", int'(timeout_err), 0);
        check("to_stall_clear", int'(stall), 0);

        // load into r0
        set_ex(1, 0, 0, 9, 0);
        tick();
`ifdef ZERO_REG_NOHAZARD_EN
        check("r0_stall", int'(stall), 0);
`else
        check("r0_stall", int'(stall), 1);
`endif
        set_ex(0, 0, 0, 9, 0);
        tick();

        // random traffic with memory busy bursts and occasional reset
        busy_left = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (busy_left > 0) begin mem_busy = 1; busy_left--; end
            else if ($urandom_range(0, 7) == 0) busy_left = $urandom_range(1, 11);
            else mem_busy = 0;
            id_valid     = $urandom_range(0, 3) != 0;
            ex_write     = $urandom_range(0, 1);
            ex_ReadMem   = $urandom_range(0, 1);
            id_immediate = $urandom_range(0, 1);
            ex_writeReg  = REG_W'($urandom_range(0, 3));
            id_readReg0  = REG_W'($urandom_range(0, 3));
            id_readReg1  = REG_W'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
